shift_add_datapath: RTL

- Unsigned shift-add multiplier datapath; the stage directly downstream of the multiplier FSM controller.
- Consumes the controller's load/loadAC/rstAC/shift/count16set/count16reset strobes.
- Holds the multiplicand, the multiplier/low-product register, the accumulator and the iteration counter.
- Returns count16done to the controller and presents the 2*WIDTH product with a valid flag.

---
 rtl/shift_add_datapath.sv | 132 +++++++++++++
 1 files changed

// File: rtl/shift_add_datapath.sv
// ---------------------------------------------------------------------------
// shift_add_datapath
//
// Datapath half of an unsigned shift-add multiplier. It holds the
// multiplicand (M), the multiplier / low-product register (Q), the
// accumulator (AC) with its carry bit (C) and the iteration counter. The
// companion FSM controller drives it one strobe per operation.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset (0 = reset)
//   load          capture operands: M <= data_a, Q <= data_b
//   loadAC        conditional add: {C,AC} <= AC + (Q[0] ? M : 0)
//   rstAC         synchronous clear of AC and C
//   shift         logical right shift of {C,AC,Q} by one
//   count16set    increment the iteration counter (wraps at WIDTH-1)
//   count16reset  synchronous clear of the iteration counter
//   data_a        multiplicand
//   data_b        multiplier
//   count16done   high while the counter sits on the last iteration
//   product       {AC,Q}
//   product_valid product holds a completed result
// ---------------------------------------------------------------------------
module shift_add_datapath #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               loadAC,
  input  logic               rstAC,
  input  logic               shift,
  input  logic               count16set,
  input  logic               count16reset,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  output logic               count16done,
  output logic [2*WIDTH-1:0] product,
  output logic               product_valid
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_ac;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_valid;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic             w_qIn;

  // Partial product for this iteration, kept WIDTH+1 wide so the carry of
  // the largest operands lands in C instead of being lost.
  assign w_addend = r_q[0] ? r_m : '0;
  assign w_sum    = {1'b0, r_ac} + {1'b0, w_addend};

  // Bit entering Q's MSB on a shift: the fresh sum's LSB when add and shift
  // are fused, otherwise the current AC LSB (a clearing rstAC still lets the
  // old AC bit fall into Q).
  assign w_qIn = (loadAC && !rstAC) ? w_sum[0] : r_ac[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m <= '0;
    end else if (load) begin
      r_m <= data_a;
    end
  end

  // Operand load takes precedence over shifting Q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= data_b;
    end else if (shift) begin
      r_q <= {w_qIn, r_q[WIDTH-1:1]};
    end
  end

  // A fused add+shift shifts the full WIDTH+1 sum, so the carry enters AC's
  // MSB and C is left empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ac <= '0;
      r_c  <= 1'b0;
    end else if (rstAC) begin
      r_ac <= '0;
      r_c  <= 1'b0;
    end else if (loadAC && shift) begin
      r_ac <= w_sum[WIDTH:1];
      r_c  <= 1'b0;
    end else if (loadAC) begin
      {r_c, r_ac} <= w_sum;
    end else if (shift) begin
      r_ac <= {r_c, r_ac[WIDTH-1:1]};
      r_c  <= 1'b0;
    end
  end

  // Explicit wrap keeps the count correct when WIDTH is not a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (count16reset) begin
      r_cnt <= '0;
    end else if (count16set) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  // Valid rises on the final fused iteration and survives idle cycles until
  // the next operand load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b0;
    end else if (count16done && shift && loadAC) begin
      r_valid <= 1'b1;
    end
  end

  assign count16done   = (r_cnt == LAST);
  assign product       = {r_ac, r_q};
  assign product_valid = r_valid;

endmodule
